// File: rtl/sdram_rom_sched.sv
// rtl/sdram_rom_sched.sv - shares one SDRAM command port between the ROM download writer and three ROM readers
// Download writes win; reads issue on address change and are served round-robin.
module sdram_rom_sched #(
  parameter logic [22:0] SND_BASE = 23'h004000,
  parameter logic [22:0] SP_BASE  = 23'h008000
) (
  input  logic        clk,
  input  logic        init_n,
  input  logic        dl_active,
  input  logic        dl_wr,
  input  logic [23:0] dl_addr,
  input  logic [7:0]  dl_data,
  output logic        dl_ovf,
  input  logic [13:0] cpu1_addr,
  output logic [15:0] cpu1_q,
  input  logic [12:0] cpu2_addr,
  output logic [15:0] cpu2_q,
  input  logic [14:0] sp_addr,
  output logic [31:0] sp_q,
  output logic        mem_req,
  output logic        mem_we,
  output logic [22:0] mem_addr,
  output logic [1:0]  mem_ds,
  output logic [15:0] mem_d,
  input  logic        mem_busy,
  input  logic        mem_rdy,
  input  logic [15:0] mem_q
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SP2, S_SP2W} state_t;
  localparam logic [1:0] G_CPU1 = 2'd0;
  localparam logic [1:0] G_CPU2 = 2'd1;
  localparam logic [1:0] G_SP   = 2'd2;
  localparam logic [1:0] G_DL   = 2'd3;

  state_t      r_state;
  logic [1:0]  r_gnt;
  logic [1:0]  r_ptr;
  logic [14:0] r_lat;
  logic        r_dl_pend;
  logic [22:0] r_dl_addr;
  logic [1:0]  r_dl_ds;
  logic [15:0] r_dl_d;
  logic [13:0] r_last1;
  logic [12:0] r_last2;
  logic [14:0] r_last_sp;
  logic [2:0]  r_valid;
  logic        r_dl_act_d;
  logic        r_kill;
  logic [15:0] r_sp_lo;

  logic [3:0]  w_pend;
  logic [1:0]  w_c0, w_c1, w_c2;
  logic        w_rd_ok;
  logic [1:0]  w_rd_sel;
  logic [22:0] w_rd_addr;
  logic [14:0] w_raw;
  logic        w_dl_issue;

  function automatic logic [1:0] nxt(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign w_pend[0] = !dl_active && (!r_valid[0] || cpu1_addr != r_last1);
  assign w_pend[1] = !dl_active && (!r_valid[1] || cpu2_addr != r_last2);
  assign w_pend[2] = !dl_active && (!r_valid[2] || sp_addr != r_last_sp);
  assign w_pend[3] = 1'b0;

  assign w_c0 = r_ptr;
  assign w_c1 = nxt(w_c0);
  assign w_c2 = nxt(w_c1);
  assign w_dl_issue = (r_state == S_IDLE) && !mem_busy && r_dl_pend;

  always_comb begin
    w_rd_ok  = 1'b1;
    w_rd_sel = w_c0;
    if (w_pend[w_c0])      w_rd_sel = w_c0;
    else if (w_pend[w_c1]) w_rd_sel = w_c1;
    else if (w_pend[w_c2]) w_rd_sel = w_c2;
    else                   w_rd_ok  = 1'b0;
  end

  always_comb begin
    w_rd_addr = {9'd0, cpu1_addr};
    w_raw     = {1'b0, cpu1_addr};
    case (w_rd_sel)
      G_CPU2: begin
        w_rd_addr = SND_BASE + {10'd0, cpu2_addr};
        w_raw     = {2'b00, cpu2_addr};
      end
      G_SP: begin
        w_rd_addr = SP_BASE + {7'd0, sp_addr, 1'b0};
        w_raw     = sp_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!init_n) begin
      r_state    <= S_IDLE;
      r_gnt      <= G_CPU1;
      r_ptr      <= G_CPU1;
      r_lat      <= '0;
      r_dl_pend  <= 1'b0;
      r_dl_addr  <= '0;
      r_dl_ds    <= '0;
      r_dl_d     <= '0;
      r_last1    <= '0;
      r_last2    <= '0;
      r_last_sp  <= '0;
      r_valid    <= '0;
      r_dl_act_d <= 1'b0;
      r_kill     <= 1'b0;
      r_sp_lo    <= '0;
      dl_ovf     <= 1'b0;
      cpu1_q     <= '0;
      cpu2_q     <= '0;
      sp_q       <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_ds     <= '0;
      mem_d      <= '0;
    end else begin
      mem_req    <= 1'b0;
      r_dl_act_d <= dl_active;

      // A new byte arriving on the issue cycle replaces the entry without counting as overflow.
      if (dl_wr) begin
        r_dl_pend <= 1'b1;
        r_dl_addr <= dl_addr[23:1];
        r_dl_ds   <= {dl_addr[0], ~dl_addr[0]};
        r_dl_d    <= {dl_data, dl_data};
        if (r_dl_pend && !w_dl_issue) dl_ovf <= 1'b1;
      end else if (w_dl_issue) begin
        r_dl_pend <= 1'b0;
      end

      case (r_state)
        S_IDLE: if (!mem_busy) begin
          if (r_dl_pend) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b1;
            mem_addr <= r_dl_addr;
            mem_ds   <= r_dl_ds;
            mem_d    <= r_dl_d;
            r_gnt    <= G_DL;
            r_state  <= S_WAIT;
          end else if (w_rd_ok) begin
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= w_rd_addr;
            mem_ds   <= 2'b11;
            mem_d    <= '0;
            r_gnt    <= w_rd_sel;
            r_lat    <= w_raw;
            r_ptr    <= nxt(w_rd_sel);
            r_kill   <= 1'b0;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: if (mem_rdy) begin
          case (r_gnt)
            G_CPU1: begin
              cpu1_q     <= mem_q;
              r_last1    <= r_lat[13:0];
              r_valid[0] <= !r_kill;
              r_state    <= S_IDLE;
            end
            G_CPU2: begin
              cpu2_q     <= mem_q;
              r_last2    <= r_lat[12:0];
              r_valid[1] <= !r_kill;
              r_state    <= S_IDLE;
            end
            G_SP: begin
              r_sp_lo <= mem_q;
              r_state <= S_SP2;
            end
            default: r_state <= S_IDLE;
          endcase
        end
        S_SP2: if (!mem_busy) begin
          mem_req  <= 1'b1;
          mem_addr <= mem_addr + 23'd1;
          r_state  <= S_SP2W;
        end
        S_SP2W: if (mem_rdy) begin
          sp_q       <= {mem_q, r_sp_lo};
          r_last_sp  <= r_lat;
          r_valid[2] <= !r_kill;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // Download start forces every reader to refetch; an in-flight read must not revalidate.
      if (dl_active && !r_dl_act_d) begin
        r_valid <= '0;
        r_kill  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sdram_rom_sched.sv
// tb/tb_sdram_rom_sched.sv - scoreboard bench for sdram_rom_sched with a latency-3 memory responder
module tb_sdram_rom_sched;

  logic        clk = 1'b0;
  logic        init_n, dl_active, dl_wr;
  logic [23:0] dl_addr;
  logic [7:0]  dl_data;
  logic        dl_ovf;
  logic [13:0] cpu1_addr;
  logic [15:0] cpu1_q;
  logic [12:0] cpu2_addr;
  logic [15:0] cpu2_q;
  logic [14:0] sp_addr;
  logic [31:0] sp_q;
  logic        mem_req, mem_we;
  logic [22:0] mem_addr;
  logic [1:0]  mem_ds;
  logic [15:0] mem_d;
  logic        mem_busy;
  logic        mem_rdy = 1'b0;
  logic [15:0] mem_q = 16'h0;

  sdram_rom_sched dut (
    .clk(clk), .init_n(init_n), .dl_active(dl_active), .dl_wr(dl_wr),
    .dl_addr(dl_addr), .dl_data(dl_data), .dl_ovf(dl_ovf),
    .cpu1_addr(cpu1_addr), .cpu1_q(cpu1_q), .cpu2_addr(cpu2_addr), .cpu2_q(cpu2_q),
    .sp_addr(sp_addr), .sp_q(sp_q), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_ds(mem_ds), .mem_d(mem_d), .mem_busy(mem_busy),
    .mem_rdy(mem_rdy), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int busy_viol = 0;
  int sp_chg = 0;
  int inj_cnt = 0;
  int inj_seen = 0;
  int cnt = 0;
  logic rsp_en;
  logic [31:0] sp_prev = 32'h0;
  logic [22:0] p_addr;
  logic        p_we;
  logic [41:0] exp_q[$];
  logic [41:0] obs_q[$];
  logic [15:0] mem [int unsigned];

  function automatic logic [15:0] rd(input logic [22:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return a[15:0] ^ 16'hC3C3;
  endfunction

  // Memory responder: records every command, answers 3 cycles later.
  always @(negedge clk) begin
    mem_rdy = 1'b0;
    if (inj_cnt != inj_seen) begin
      inj_seen = inj_cnt;
      mem_rdy  = 1'b1;
      mem_q    = 16'hDEAD;
    end
    if (mem_req) begin
      obs_q.push_back({mem_we, mem_addr, mem_ds, mem_d});
      if (mem_busy) busy_viol++;
      p_we = mem_we; p_addr = mem_addr; cnt = 3;
    end else if (cnt > 0) begin
      cnt--;
      if (cnt == 0 && rsp_en) begin
        mem_rdy = 1'b1;
        if (!p_we) mem_q = rd(p_addr);
      end
    end
    if (sp_q !== sp_prev) sp_chg++;
    sp_prev = sp_q;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic push_rd(input logic [22:0] a);
    exp_q.push_back({1'b0, a, 2'b11, 16'h0});
  endtask

  task automatic push_wr(input logic [22:0] a, input logic [1:0] ds, input logic [15:0] d);
    exp_q.push_back({1'b1, a, ds, d});
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_sb(input string tag);
    logic [41:0] e, o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : '1;
      if (!e[41]) o[15:0] = 16'h0;
      chk(tag, {22'd0, o}, {22'd0, e});
    end
    chk({tag, "_extra"}, 64'(obs_q.size()), 64'd0);
    obs_q.delete();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req"}, {63'd0, mem_req}, 64'd0);
    chk({tag, "_we"}, {63'd0, mem_we}, 64'd0);
    chk({tag, "_addr"}, {41'd0, mem_addr}, 64'd0);
    chk({tag, "_ds"}, {62'd0, mem_ds}, 64'd0);
    chk({tag, "_d"}, {48'd0, mem_d}, 64'd0);
    chk({tag, "_cpu1q"}, {48'd0, cpu1_q}, 64'd0);
    chk({tag, "_cpu2q"}, {48'd0, cpu2_q}, 64'd0);
    chk({tag, "_spq"}, {32'd0, sp_q}, 64'd0);
    chk({tag, "_ovf"}, {63'd0, dl_ovf}, 64'd0);
  endtask

  task automatic chk_reads(input string tag);
    chk({tag, "_cpu1q"}, {48'd0, cpu1_q}, {48'd0, rd({9'd0, cpu1_addr})});
    chk({tag, "_cpu2q"}, {48'd0, cpu2_q}, {48'd0, rd(23'h004000 + {10'd0, cpu2_addr})});
    chk({tag, "_spq"}, {32'd0, sp_q},
        {32'd0, rd(23'h008001 + {7'd0, sp_addr, 1'b0}), rd(23'h008000 + {7'd0, sp_addr, 1'b0})});
  endtask

  int sp_base;

  initial begin
    init_n = 1'b0; dl_active = 1'b1; dl_wr = 1'b0; dl_addr = '0; dl_data = '0;
    cpu1_addr = 14'h0123; cpu2_addr = 13'h0010; sp_addr = 15'h0002;
    mem_busy = 1'b0; rsp_en = 1'b1;
    mem[32'h000123] = 16'h1234; mem[32'h004010] = 16'h5678;
    mem[32'h008004] = 16'h1111; mem[32'h008005] = 16'h2222;
    settle(3);
    chk_reset_outs("reset");
    init_n = 1'b1;
    settle(1);

    // Single download byte, with command latency
    dl_addr = 24'h010001; dl_data = 8'hA5; dl_wr = 1'b1;
    push_wr(23'h008000, 2'b10, 16'hA5A5);
    settle(1); dl_wr = 1'b0;
    chk("dl_lat1", {63'd0, mem_req}, 64'd0);
    settle(1);
    chk("dl_lat2", {63'd0, mem_req}, 64'd1);
    settle(10);
    check_sb("dl_wr");
    chk("dl_ovf_clear", {63'd0, dl_ovf}, 64'd0);

    // Two bytes back-to-back while the engine is busy
    mem_busy = 1'b1;
    dl_addr = 24'h000010; dl_data = 8'h11; dl_wr = 1'b1;
    settle(1);
    dl_addr = 24'h000021; dl_data = 8'h22;
    settle(1); dl_wr = 1'b0;
    settle(3);
    chk("busy_hold", 64'(obs_q.size()), 64'd0);
    push_wr(23'h000010, 2'b10, 16'h2222);
    mem_busy = 1'b0;
    settle(10);
    check_sb("dl_ovf_wr");
    chk("dl_ovf_set", {63'd0, dl_ovf}, 64'd1);

    // First reads after download: cpu1, cpu2, sprite pair
    push_rd(23'h000123); push_rd(23'h004010); push_rd(23'h008004); push_rd(23'h008005);
    sp_base = sp_chg;
    dl_active = 1'b0;
    settle(40);
    check_sb("init_reads");
    chk("cpu1_q", {48'd0, cpu1_q}, 64'h1234);
    chk("cpu2_q", {48'd0, cpu2_q}, 64'h5678);
    chk("sp_q", {32'd0, sp_q}, 64'h22221111);
    chk("sp_atomic", 64'(sp_chg - sp_base), 64'd1);
    settle(20);
    check_sb("no_reread");

    // Round-robin: pointer sits at cpu1
    cpu1_addr = 14'h0200; cpu2_addr = 13'h0021;
    push_rd(23'h000200); push_rd(23'h004021);
    settle(30);
    check_sb("rr_a");
    chk_reads("rr_a");

    // Pointer now after cpu2: sprite first
    cpu1_addr = 14'h0201; sp_addr = 15'h0011;
    push_rd(23'h008022); push_rd(23'h008023); push_rd(23'h000201);
    settle(40);
    check_sb("rr_b");
    chk_reads("rr_b");

    // Pointer after cpu1: cpu2, sp, cpu1
    cpu1_addr = 14'h0202; cpu2_addr = 13'h0022; sp_addr = 15'h0012;
    push_rd(23'h004022); push_rd(23'h008024); push_rd(23'h008025); push_rd(23'h000202);
    settle(50);
    check_sb("rr_c");
    chk_reads("rr_c");

    // Download window invalidates all readers
    dl_active = 1'b1;
    settle(10);
    check_sb("dl_quiet");
    push_rd(23'h004022); push_rd(23'h008024); push_rd(23'h008025); push_rd(23'h000202);
    dl_active = 1'b0;
    settle(50);
    check_sb("dl_reread");

    // Reset while a read is outstanding; stray rdy afterwards is ignored
    cpu1_addr = 14'h0777; rsp_en = 1'b0;
    push_rd(23'h000777);
    settle(8);
    check_sb("abort_req");
    dl_active = 1'b1; init_n = 1'b0;
    settle(2);
    chk_reset_outs("mid_reset");
    init_n = 1'b1; rsp_en = 1'b1;
    settle(1);
    inj_cnt++;
    settle(5);
    chk("late_rdy_cpu1q", {48'd0, cpu1_q}, 64'd0);
    chk("late_rdy_spq", {32'd0, sp_q}, 64'd0);
    check_sb("late_rdy_quiet");
    push_rd(23'h000777); push_rd(23'h004022); push_rd(23'h008024); push_rd(23'h008025);
    dl_active = 1'b0;
    settle(50);
    check_sb("post_reset");
    chk_reads("post_reset");

    chk("busy_gate", 64'(busy_viol), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sdram_rom_sched.md
# sdram_rom_sched

Request scheduler that shares the single SDRAM command engine between the ROM download writer, main-CPU ROM fetch, sound-CPU ROM fetch and 32-bit sprite graphics fetch. It sits between the game core's ROM ports and the SDRAM controller's single command port, in the `clk_sd` domain.

- Reads issue only when a requester's address changes; results are held per requester.
- Download writes take strict priority.
- The three read requesters are served round-robin.

## Interface
Parameters:
- `SND_BASE`, 23'h004000, word base added to the sound-CPU word address.
- `SP_BASE`, 23'h008000, word base of the sprite region; sprite word pair at `SP_BASE + {sp_addr,1'b0}` and `+1`.

Ports:
- `clk`  in  1  SDRAM-domain clock (`clk_sd`).
- `init_n`  in  1  reset. Synchronous, active-low.
- `dl_active`  in  1  ROM download in progress; while high, all reads are suppressed.
- `dl_wr`  in  1  single-cycle pulse: download byte valid.
- `dl_addr`  in  24  download byte address.
- `dl_data`  in  8  download byte.
- `dl_ovf`  out  1  sticky: a `dl_wr` arrived while the previous write was still unissued.
- `cpu1_addr`  in  14  main-CPU word address (word base 0).
- `cpu1_q`  out  16  last main-CPU read data.
- `cpu2_addr`  in  13  sound-CPU word address.
- `cpu2_q`  out  16  last sound-CPU read data.
- `sp_addr`  in  15  sprite 32-bit word index.
- `sp_q`  out  32  last sprite data: {second word, first word}.
- `mem_req`  out  1  single-cycle command strobe.
- `mem_we`  out  1  write command.
- `mem_addr`  out  23  word address.
- `mem_ds`  out  2  byte strobes {hi, lo}.
- `mem_d`  out  16  write data.
- `mem_busy`  in  1  engine cannot accept a command.
- `mem_rdy`  in  1  single-cycle pulse: read data valid, or write complete.
- `mem_q`  in  16  read data.

## Operation
- **Download buffer:** one entry.
  - On `dl_wr`, capture `mem_addr = dl_addr[23:1]`, `mem_ds = {dl_addr[0], ~dl_addr[0]}` and `mem_d = {dl_data, dl_data}`, and set `dl_pend`.
  - If `dl_wr` arrives while `dl_pend` is set, overwrite the entry and set `dl_ovf`.
  - `dl_ovf` clears only on reset.
- **Read pending rule:** requester *r* is pending when `!dl_active` and either `valid_r` is 0 or the current address ≠ `last_r`.
  - `last_r` and `valid_r` update when that requester's read completes.
  - The address used is the one latched at grant.
- **Arbitration:** evaluated in `IDLE` only, when `!mem_busy`.
  - `dl_pend` wins first.
  - Otherwise round-robin over cpu1 → cpu2 → sp, starting after the last granted reader.
  - The pointer resets to point at cpu1.
- **State machine:**
  - `IDLE`: on a grant, drive `mem_req` for 1 cycle with the chosen command and go to `WAIT`. A write clears `dl_pend` at issue.
  - `WAIT`: on `mem_rdy`:
    - Write: go to `IDLE`.
    - cpu1 or cpu2 read: load `*_q` from `mem_q`, update `last`/`valid`, go to `IDLE`.
    - First sprite word: store it in `sp_lo`, go to `SP2`.
  - `SP2`: when `!mem_busy`, issue the read of word `+1` (`mem_req` for 1 cycle) and go to `SP2W`.
  - `SP2W`: on `mem_rdy`, set `sp_q = {mem_q, sp_lo}`, update `last_sp`, go to `IDLE`.
    - `sp_q` changes atomically; it is never half-updated.
- **`dl_active` rising:** clears all `valid_r`, so every requester re-reads after the download.
  - A read already in flight completes and updates its `*_q`, but its `valid_r` stays 0.
- **Address math:**
  - cpu2: `SND_BASE + cpu2_addr`, truncated to 23 bits.
  - sp: `SP_BASE + {sp_addr,1'b0}`; wrap-around modulo 2^23 is allowed.
- **Reads:** `mem_ds` = 2'b11 and `mem_we` = 0.

## Timing
- **Reset:** synchronous (`init_n` low at a `clk` edge), takes effect within 1 cycle.
  - State → `IDLE`.
  - Outputs: `mem_req`/`mem_we` = 0, `mem_addr` = 0, `mem_ds` = 0, `mem_d` = 0.
  - `cpu1_q`/`cpu2_q` = 0, `sp_q` = 0, `dl_ovf` = 0.
  - Internal: `dl_pend` and `valid_*` cleared.
  - Reset mid-transaction abandons it; late `mem_rdy` pulses in `IDLE` are ignored.
- **Command latency:** `mem_req` asserts the cycle after the grant condition is registered. Minimum `dl_wr` → `mem_req` is 2 cycles.
- **Read latency:** read data reaches `*_q` the cycle after `mem_rdy`.
  - `mem_addr`/`mem_we`/`mem_ds`/`mem_d` are stable from `mem_req` until `mem_rdy`.
- **Command gating:** `mem_req` never asserts while `mem_busy` = 1, and never while in `WAIT` or `SP2W`.
  - At most one outstanding command.
- **Simultaneous events:**
  - `dl_wr` in the same cycle as a read grant: the read proceeds; the write is next.
  - `mem_rdy` and an address change in the same cycle: data is attributed to the latched address, and the new address becomes pending.

## Test plan
- **Download write:** `dl_wr` with `dl_addr`=24'h010001, `dl_data`=8'hA5 → one `mem_req` with `mem_we`=1, `mem_addr`=23'h008000, `mem_ds`=2'b10, `mem_d`=16'hA5A5; `dl_ovf` stays 0.
- **Download overflow:** two `dl_wr` 1 cycle apart with `mem_busy` held high → `dl_ovf`=1; only the second byte is written.
- **Address-change reads:** `cpu1_addr`=14'h0123 held; memory returns 16'h1234 → exactly one read at 23'h000123 and `cpu1_q`=16'h1234; no further reads until the address changes.
- **Sprite pair:** `sp_addr`=15'h0002; memory returns 16'h1111 then 16'h2222 → reads at 23'h008004 and 23'h008005; `sp_q`=32'h22221111 updated in one cycle.
- **Round-robin fairness:** cpu1, cpu2 and sp all change address every completion → grant order cpu1, cpu2, sp, cpu1…; no requester waits more than 2 other grants.
- **Reset mid-read:** pulse `init_n` low during `WAIT`, then deliver `mem_rdy` → all outputs 0, no `*_q` update; the read re-issues after reset.
